// File: rtl/audio_output_buffer.sv
// Receive-side frame buffer: packs the real part of incoming complex samples
// into wide words in a frame memory that the CPU reads back one word at a time.
module audio_output_buffer #(
  parameter int SIZE             = 16,
  parameter int OUTPUT_SIZE      = 512,
  parameter int SAMPLES          = 2048,
  localparam int SAMPLES_PER_WORD = OUTPUT_SIZE / SIZE,
  localparam int WORDS            = SAMPLES * SIZE / OUTPUT_SIZE,
  localparam int IDX_W            = $clog2(WORDS),
  localparam int CNT_W            = $clog2(SAMPLES),
  localparam int LANE_W           = $clog2(SAMPLES_PER_WORD)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [2*SIZE-1:0]      in_sample,
  input  logic [IDX_W-1:0]       rd_index,
  output logic [OUTPUT_SIZE-1:0] rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic [CNT_W-1:0]       sample_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [OUTPUT_SIZE-1:0] staging, staging_nxt;
  logic [OUTPUT_SIZE-1:0] mem [WORDS];

  logic signed [SIZE-1:0] sample_re;
  logic                   unused_imag;
  logic [LANE_W-1:0]      lane;
  logic [IDX_W-1:0]       word;
  logic                   accept, arm, stray, last_lane, last_sample;

  assign sample_re   = in_sample[2*SIZE-1:SIZE];
  assign unused_imag = ^in_sample[SIZE-1:0];
  assign lane        = sample_count[LANE_W-1:0];
  assign word        = sample_count[CNT_W-1:LANE_W];
  assign accept      = (state_q == COLLECT) && in_valid;
  assign arm         = (state_q != COLLECT) && start;
  assign stray       = (state_q != COLLECT) && in_valid;
  assign last_lane   = &lane;
  assign last_sample = &sample_count;

  assign busy = (state_q == COLLECT);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (accept && last_sample) state_d = DONE;
      DONE:    if (start) state_d = COLLECT;
      default: state_d = IDLE;
    endcase
  end

  // Staging word with the current sample dropped into its lane; on lane 31
  // this is the complete word written to memory at the same edge.
  always_comb begin
    staging_nxt = staging;
    staging_nxt[lane*SIZE +: SIZE] = sample_re;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_count <= '0;
      staging      <= '0;
      overrun      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        sample_count <= '0;
        overrun      <= 1'b0;
      end else if (accept) begin
        sample_count <= sample_count + 1'b1;
        staging      <= staging_nxt;
      end else if (stray) begin
        overrun <= 1'b1;
      end
    end
  end

  // Frame memory is never cleared; the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (!rst && accept && last_lane)
      mem[word] <= staging_nxt;
    if (rst)
      rd_data <= '0;
    else
      rd_data <= mem[rd_index];
  end

endmodule

// File: tb/tb_audio_output_buffer.sv
// Directed bench for audio_output_buffer: ramp, gapped, stray, collision,
// mid-frame reset and ignored-start frames with immediate-assertion checks.
module tb_audio_output_buffer;

  logic         clk = 1'b0;
  logic         rst, start, in_valid;
  logic [31:0]  in_sample;
  logic [5:0]   rd_index;
  logic [511:0] rd_data;
  logic         busy, done, overrun;
  logic [10:0]  sample_count;

  int n_cmp = 0;
  int n_err = 0;

  audio_output_buffer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_sample(in_sample), .rd_index(rd_index), .rd_data(rd_data),
    .busy(busy), .done(done), .overrun(overrun), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word w of a frame whose sample n has real part base+n.
  function automatic logic [511:0] frame_word(input logic [15:0] base, input int w);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[16*k +: 16] = base + 16'(32*w + k);
    return r;
  endfunction

  task automatic send(input logic [15:0] re);
    in_valid  = 1'b1;
    in_sample = {re, 16'hFFFF};
    tick();
    in_valid  = 1'b0;
    in_sample = 32'h0;
  endtask

  task automatic read_word(input int w, input logic [15:0] base, input string tag);
    rd_index = 6'(w);
    tick();
    chk(tag, rd_data, frame_word(base, w));
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [511:0] w5;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_sample = 32'h0; rd_index = 6'd0;
    tick(); tick();
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_overrun", 512'(overrun), 512'(0));
    chk("rst_count", 512'(sample_count), 512'(0));
    chk("rst_rd_data", rd_data, 512'(0));
    rst = 1'b0;

    // Stray sample while idle
    send(16'h1234);
    chk("idle_stray_overrun", 512'(overrun), 512'(1));
    chk("idle_stray_count", 512'(sample_count), 512'(0));
    chk("idle_stray_busy", 512'(busy), 512'(0));

    // Ramp frame
    arm();
    chk("arm_busy", 512'(busy), 512'(1));
    chk("arm_overrun_clr", 512'(overrun), 512'(0));
    chk("arm_count", 512'(sample_count), 512'(0));
    for (int n = 0; n < 2048; n++) begin
      send(16'(n));
      if (n == 2046) chk("ramp_not_done_early", 512'(done), 512'(0));
      if (n == 40) chk("ramp_count_41", 512'(sample_count), 512'(41));
    end
    chk("ramp_done", 512'(done), 512'(1));
    chk("ramp_busy_low", 512'(busy), 512'(0));
    chk("ramp_count_wrap", 512'(sample_count), 512'(0));
    for (int k = 0; k < 32; k++) w5[16*k +: 16] = 16'(160 + k);
    rd_index = 6'd5;
    tick();
    chk("ramp_word5", rd_data, w5);
    for (int w = 0; w < 64; w++) read_word(w, 16'h0000, $sformatf("ramp_w%0d", w));

    // Stray sample while done
    send(16'hDEAD);
    chk("done_stray_overrun", 512'(overrun), 512'(1));
    chk("done_stray_done", 512'(done), 512'(1));
    chk("done_stray_count", 512'(sample_count), 512'(0));
    read_word(0, 16'h0000, "done_stray_mem0");
    read_word(63, 16'h0000, "done_stray_mem63");

    // Gapped ramp frame
    arm();
    chk("gap_arm_done_clr", 512'(done), 512'(0));
    chk("gap_arm_overrun_clr", 512'(overrun), 512'(0));
    for (int n = 0; n < 2048; n++) begin
      send(16'(n));
      tick();
      if (n == 99) chk("gap_count_hold", 512'(sample_count), 512'(100));
      if (n == 2046) chk("gap_not_done_early", 512'(done), 512'(0));
    end
    chk("gap_done", 512'(done), 512'(1));
    for (int w = 0; w < 64; w++) read_word(w, 16'h0000, $sformatf("gap_w%0d", w));

    // Collision on word 0, then reset after 700 samples
    arm();
    for (int n = 0; n < 31; n++) send(16'hA000 + 16'(n));
    rd_index = 6'd0;
    send(16'hA000 + 16'd31);
    chk("collide_old_word0", rd_data, frame_word(16'h0000, 0));
    tick();
    chk("collide_new_word0", rd_data, frame_word(16'hA000, 0));
    for (int n = 32; n < 700; n++) send(16'hA000 + 16'(n));
    chk("pre_rst_count", 512'(sample_count), 512'(700));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 512'(busy), 512'(0));
    chk("midrst_done", 512'(done), 512'(0));
    chk("midrst_count", 512'(sample_count), 512'(0));
    chk("midrst_rd_data", rd_data, 512'(0));
    read_word(1, 16'hA000, "midrst_kept_w1");
    read_word(20, 16'hA000, "midrst_kept_w20");
    read_word(21, 16'h0000, "midrst_old_w21");
    chk("midrst_done_still_low", 512'(done), 512'(0));

    // Full frame with an ignored start after 100 samples
    arm();
    for (int n = 0; n < 100; n++) send(16'hB000 + 16'(n));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start_busy", 512'(busy), 512'(1));
    chk("ign_start_count", 512'(sample_count), 512'(100));
    send(16'hB000 + 16'd100);
    chk("ign_start_count_101", 512'(sample_count), 512'(101));
    for (int n = 101; n < 2048; n++) begin
      send(16'hB000 + 16'(n));
      if (n == 2046) chk("ign_not_done_early", 512'(done), 512'(0));
    end
    chk("ign_done", 512'(done), 512'(1));
    chk("ign_overrun", 512'(overrun), 512'(0));
    for (int w = 0; w < 64; w++) read_word(w, 16'hB000, $sformatf("ign_w%0d", w));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/audio_output_buffer.md
Name: audio_output_buffer

Overview:
- Receive end of the audio pipeline: accepts one processed complex sample per cycle from the pitch-shift/inverse-FFT stage.
- Keeps the real part and packs samples into wide words in a frame memory.
- The CPU reads the frame back one wide word at a time (STE path), selected by an index.
- Mirror of the wide-word-in / serial-out input buffer: wide words out, serial samples in, same packing order.

Parameters:
- SIZE, 16, bits per stored real sample.
- OUTPUT_SIZE, 512, bits per CPU-visible word.
- SAMPLES, 2048, samples per frame.
- SAMPLES_PER_WORD, OUTPUT_SIZE/SIZE = 32 (derived localparam).
- WORDS, SAMPLES*SIZE/OUTPUT_SIZE = 64 (derived localparam).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  arm buffer for a new frame (issued with SYN).
- in_valid  input  1  in_sample carries a valid sample this cycle.
- in_sample  input  2*SIZE  complex sample: [31:16] real, [15:0] imaginary (imaginary discarded).
- rd_index  input  $clog2(WORDS)  word select for CPU readback.
- rd_data  output  OUTPUT_SIZE  registered word mem[rd_index].
- busy  output  1  high while collecting.
- done  output  1  frame complete, memory holds a full frame.
- overrun  output  1  sticky: a valid sample arrived while not collecting.
- sample_count  output  $clog2(SAMPLES)  samples accepted in the current frame.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; sample_count=0; staging register=0.
  - busy=0, done=0, overrun=0, rd_data=0.
  - Frame memory is not cleared.
- States:
  - IDLE --start--> COLLECT.
  - COLLECT --accept of sample 2047--> DONE.
  - DONE --start--> COLLECT.
  - No other transitions.
- start in IDLE or DONE:
  - next cycle state=COLLECT, sample_count=0, done=0, overrun=0.
  - A sample presented in the same cycle as start is not accepted.
- start while in COLLECT is ignored; the frame continues.
- Accept in COLLECT with in_valid=1:
  - lane k = sample_count[4:0]; word w = sample_count[10:5].
  - in_sample[31:16] goes into staging bits [16k+15:16k].
  - sample_count increments.
- Packing order: frame sample n = 32*w + k lives in word w at bits [16k+15:16k]. Lane 0 is the LSBs, matching the input buffer's unpacking.
- Word write: when k==31, mem[w] is written at that same edge with the staging contents plus the new lane-31 sample (the complete word). No extra cycle is needed.
- Final sample: accepting sample 2047 (sample_count==2047, in_valid) writes word 63, moves state to DONE, sets done=1 and sets sample_count to 0 (wraps).
- Gaps: in_valid=0 in COLLECT stalls; nothing changes.
- Stray samples: in_valid=1 in IDLE or DONE ignores the data and sets overrun=1 (sticky until start or rst).
- Outputs: busy = (state==COLLECT); done = (state==DONE), registered.
- Readback:
  - rd_data <= mem[rd_index] every non-reset cycle, so 1-cycle latency.
  - Readback is legal in any state.
  - If rd_index targets the word being written in the same cycle, rd_data returns the old contents (read-before-write). The new contents appear the following cycle.
- Reset mid-frame: collection is abandoned; partial words already written remain in memory; done stays 0 until a full new frame completes.

Test Plan:
1. Ramp frame: rst; start; 2048 consecutive valid samples with real part = n and imaginary part = 16'hFFFF.
   - done rises on the edge after sample 2047.
   - rd_index=5 -> rd_data lane k = 160+k one cycle later; imaginary bits are absent.
2. Gapped input: same frame with in_valid toggling 1,0,1,0.
   - Identical memory contents to scenario 1.
   - sample_count holds during gaps; done is asserted after the 2048th accepted sample only.
3. Stray samples: in_valid=1 in IDLE and in DONE.
   - overrun=1; sample_count and memory are unchanged.
   - The next start clears overrun and done.
4. Read/write collision: hold rd_index=0 while sample 31 of frame 2 (values 16'hA000+n) is accepted.
   - That cycle rd_data shows frame-1 word 0.
   - Next cycle rd_data shows the new word 0.
5. Reset mid-frame: rst after 700 samples.
   - busy=0, done=0, sample_count=0, rd_data=0.
   - Then start plus a full frame completes normally; all 64 words match.
6. Start during COLLECT: assert start after 100 samples.
   - Ignored; sample_count continues to 101 on the next valid sample; the frame completes at 2048 total.
